fetch_dec_queue: RTL and testbench

- Parametrised instruction buffer between fetch and decode; successor to the single-slot fetch/decode handoff.
- Decouples the fetch stage from decode back-pressure with a DEPTH-entry FIFO of {pc, inst, pred_taken_}.
- Asserts early fetch stall with a programmable margin, covering fetch-side latency.
- Supports single-cycle flush on control-flow redirect.

---
 rtl/fetch_dec_queue_if.sv | 34 +++
 rtl/fetch_dec_queue.sv | 96 +++++++++
 tb/tb_fetch_dec_queue.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fetch_dec_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue.
// The master modport is the fetch+decode side; the slave modport is the queue.
`timescale 1ns/1ps
interface fetch_dec_queue_if #(
    parameter int ADDR  = 32,
    parameter int INST  = 32,
    parameter int DEPTH = 4
);
    localparam int CNT = $clog2(DEPTH + 1);

    logic            flush;
    logic            in_e_;
    logic [ADDR-1:0] in_pc;
    logic [INST-1:0] in_inst;
    logic            in_pred_taken_;
    logic            fetch_stall;
    logic            inst_e_;
    logic [ADDR-1:0] inst_pc;
    logic [INST-1:0] inst;
    logic            inst_pred_taken_;
    logic            dec_stall;
    logic [CNT-1:0]  count;
    logic            overflow;

    modport master (
        output flush, in_e_, in_pc, in_inst, in_pred_taken_, dec_stall,
        input  fetch_stall, inst_e_, inst_pc, inst, inst_pred_taken_, count, overflow
    );

    modport slave (
        input  flush, in_e_, in_pc, in_inst, in_pred_taken_, dec_stall,
        output fetch_stall, inst_e_, inst_pc, inst, inst_pred_taken_, count, overflow
    );
endinterface

// File: rtl/fetch_dec_queue.sv
// DEPTH-entry first-word-fall-through instruction queue between fetch and decode,
// with early fetch stall, single-cycle flush and a sticky overflow flag.
`timescale 1ns/1ps
module fetch_dec_queue #(
    parameter int ADDR         = 32,
    parameter int INST         = 32,
    parameter int DEPTH        = 4,
    parameter int STALL_MARGIN = 1
) (
    input logic           clk,
    input logic           reset,
    fetch_dec_queue_if.slave q
);
    localparam int CNT = $clog2(DEPTH + 1);
    localparam int PW  = $clog2(DEPTH);

    typedef struct packed {
        logic [ADDR-1:0] pc;
        logic [INST-1:0] inst;
        logic            pred_taken_;
    } entry_t;

    entry_t         mem [DEPTH];
    logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [PW-1:0]  wr_ptr_next, rd_ptr_next;
    logic [CNT-1:0] count_reg, count_next;
    logic           overflow_reg;

    logic   empty, full, pop, push_req, push, drop;
    entry_t head;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CNT'(DEPTH));
    assign pop      = !empty && !q.dec_stall && !q.flush;
    assign push_req = !q.in_e_ && !q.flush;
    // A full queue can still take a push when the head leaves in the same cycle.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (q.flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push)
                wr_ptr_next = (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
            if (pop)
                rd_ptr_next = (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
            if (push && !pop)
                count_next = count_reg + CNT'(1);
            else if (pop && !push)
                count_next = count_reg - CNT'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            if (drop)
                overflow_reg <= 1'b1;
        end
    end

    // Entry storage carries no reset; stale slots are never exposed because outputs are gated by empty.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= '{pc: q.in_pc, inst: q.in_inst, pred_taken_: q.in_pred_taken_};
    end

    assign head               = mem[rd_ptr_reg];
    assign q.inst_e_          = empty;
    assign q.inst_pc          = empty ? '0 : head.pc;
    assign q.inst             = empty ? '0 : head.inst;
    assign q.inst_pred_taken_ = empty ? 1'b1 : head.pred_taken_;
    assign q.fetch_stall      = (count_reg >= CNT'(DEPTH - STALL_MARGIN));
    assign q.count            = count_reg;
    assign q.overflow         = overflow_reg;

    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        count_reg <= CNT'(DEPTH));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (reset)
        !(pop && empty));
    a_stall_margin: assert property (@(posedge clk) disable iff (reset)
        !q.fetch_stall |-> (count_reg < CNT'(DEPTH - STALL_MARGIN)));
endmodule

// File: tb/tb_fetch_dec_queue.sv
// Directed bench for fetch_dec_queue at DEPTH=4, STALL_MARGIN=1.
`timescale 1ns/1ps
module tb_fetch_dec_queue;
    localparam int ADDR = 32;
    localparam int INST = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    fetch_dec_queue_if #(.ADDR(ADDR), .INST(INST), .DEPTH(DEPTH)) q ();

    fetch_dec_queue #(.ADDR(ADDR), .INST(INST), .DEPTH(DEPTH), .STALL_MARGIN(1)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (q.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e_, input logic [31:0] pc, input logic [31:0] ins,
                         input logic pt_, input logic ds, input logic fl);
        q.in_e_          = e_;
        q.in_pc          = pc;
        q.in_inst        = ins;
        q.in_pred_taken_ = pt_;
        q.dec_stall      = ds;
        q.flush          = fl;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".inst_e_"}, 64'(q.inst_e_), 64'd1);
        chk({tag, ".count"}, 64'(q.count), 64'd0);
        chk({tag, ".inst_pc"}, 64'(q.inst_pc), 64'd0);
        chk({tag, ".inst"}, 64'(q.inst), 64'd0);
        chk({tag, ".pred_"}, 64'(q.inst_pred_taken_), 64'd1);
        chk({tag, ".fetch_stall"}, 64'(q.fetch_stall), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        #3;
        chk_empty("in_reset");
        chk("in_reset.overflow", 64'(q.overflow), 64'd0);
        step();
        step();
        reset = 1'b0;
        repeat (3) step();
        chk_empty("idle");
        chk("idle.overflow", 64'(q.overflow), 64'd0);

        // Fill with decode stalled; stall rises at count 3, head held.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 1'(i), 1'b1, 1'b0);
            step();
            chk($sformatf("fill%0d.count", i), 64'(q.count), 64'(i + 1));
            chk($sformatf("fill%0d.fetch_stall", i), 64'(q.fetch_stall), 64'((i + 1) >= 3));
            chk($sformatf("fill%0d.inst_pc", i), 64'(q.inst_pc), 64'h100);
            chk($sformatf("fill%0d.inst_e_", i), 64'(q.inst_e_), 64'd0);
        end

        // Push into a full queue is dropped and sets overflow.
        drive(1'b0, 32'h110, 32'hA4, 1'b1, 1'b1, 1'b0);
        step();
        chk("ovf.count", 64'(q.count), 64'd4);
        chk("ovf.overflow", 64'(q.overflow), 64'd1);
        chk("ovf.inst_pc", 64'(q.inst_pc), 64'h100);

        // Drain in order.
        drive(1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d.inst_pc", i), 64'(q.inst_pc), 64'h100 + 64'(4 * i));
            chk($sformatf("drain%0d.inst", i), 64'(q.inst), 64'hA0 + 64'(i));
            chk($sformatf("drain%0d.pred_", i), 64'(q.inst_pred_taken_), 64'(i % 2));
            step();
        end
        chk_empty("drained");
        chk("drained.overflow", 64'(q.overflow), 64'd1);

        // Streaming one per cycle across two pointer wraps.
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 32'h300 + 32'(4 * k), 32'hC0 + 32'(k), 1'(k + 1), 1'b0, 1'b0);
            step();
            chk($sformatf("stream%0d.count", k), 64'(q.count), 64'd1);
            chk($sformatf("stream%0d.inst_pc", k), 64'(q.inst_pc), 64'h300 + 64'(4 * k));
            chk($sformatf("stream%0d.inst", k), 64'(q.inst), 64'hC0 + 64'(k));
            chk($sformatf("stream%0d.pred_", k), 64'(q.inst_pred_taken_), 64'((k + 1) % 2));
        end
        drive(1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        chk_empty("stream_end");

        // Flush with three entries, simultaneous push and no decode stall.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h400 + 32'(4 * i), 32'hD0 + 32'(i), 1'b1, 1'b1, 1'b0);
            step();
        end
        chk("preflush.count", 64'(q.count), 64'd3);
        chk("preflush.fetch_stall", 64'(q.fetch_stall), 64'd1);
        drive(1'b0, 32'h200, 32'hEE, 1'b0, 1'b0, 1'b1);
        step();
        chk_empty("flush");
        chk("flush.overflow", 64'(q.overflow), 64'd1);
        drive(1'b0, 32'h204, 32'hEF, 1'b0, 1'b1, 1'b0);
        step();
        chk("postflush.count", 64'(q.count), 64'd1);
        chk("postflush.inst_pc", 64'(q.inst_pc), 64'h204);
        chk("postflush.inst", 64'(q.inst), 64'hEF);
        chk("postflush.pred_", 64'(q.inst_pred_taken_), 64'd0);

        // Asynchronous reset mid-cycle with two entries queued.
        drive(1'b0, 32'h208, 32'hF0, 1'b1, 1'b1, 1'b0);
        step();
        chk("prereset.count", 64'(q.count), 64'd2);
        drive(1'b1, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_empty("async_reset");
        chk("async_reset.overflow", 64'(q.overflow), 64'd0);
        step();
        reset = 1'b0;
        step();
        chk_empty("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
